shift_seq_ctrl: RTL
===================

// Module: shift_seq_ctrl
// PURPOSE
//   Sequencer directly upstream of the 4-bit universal shift register; drives its sel/I pins.
//   Accepts one job (data word, direction, shift count) over a valid/ready handshake.
//   Issues one parallel-load cycle, then N shift cycles, then reports done.
//   Stepping the register via sel lets it serialise a nibble without software pacing.
// PARAMETERS
//   W      4  data width; equals the shift register width
//   CNT_W  3  width of the shift-count field; must satisfy 2**CNT_W > W
// PORTS
//   clk     in   1      rising-edge clock shared with the shift register
//   rst_n   in   1      asynchronous, active-low reset
//   valid   in   1      job request; qualifies data/dir/n
//   data    in   W      word to parallel-load
//   dir     in   1      0 = shift right (sel 01), 1 = shift left (sel 10)
//   n       in   CNT_W  number of shifts after the load
//   stall   in   1      pause shifting; register holds while high
//   ready   out  1      controller idle; job accepted on valid & ready at a clk edge
//   sel     out  2      to shift register: 00 hold, 01 right, 10 left, 11 load
//   I       out  W      to shift register parallel input
//   busy    out  1      job in progress (LOAD, SHIFT or DONE)
//   done    out  1      one-cycle pulse after the last shift
// BEHAVIOUR
//   - All outputs registered (Moore); the shift register samples sel/I one edge after they change.
//   - Reset (async assert, sync release): state IDLE, sel=00, I=0, ready=1, busy=0, done=0, count=0.
//   - IDLE: sel=00, ready=1. On valid & ready at edge k:
//     - latch data, dir, n_eff = min(n, W);
//     - after edge k: state LOAD, sel=11, I=data, ready=0, busy=1.
//   - LOAD, one cycle: at edge k+1 the register loads data.
//     - n_eff>0 -> SHIFT, cnt=n_eff.
//     - n_eff==0 -> DONE.
//   - SHIFT:
//     - stall=0: sel = dir ? 10 : 01; each edge decrements cnt.
//     - stall=1: sel=00 and cnt frozen. stall is sampled registered: it takes effect on sel one cycle later.
//     - Leave SHIFT to DONE when an edge consumes the last shift. Exactly n_eff edges see sel=01/10.
//   - DONE, one cycle: sel=00, done=1, busy=1, ready=0. Then IDLE.
//   - I holds the latched data from LOAD until the next accept; it is don't-care to the register unless sel=11.
//   - valid while ready=0: ignored. No queueing; the upstream source must hold valid.
//   - Shift counts: n > W saturates to W; n=0 gives load-only.
//   - stall in IDLE/LOAD/DONE: ignored.
//   - rst_n low mid-job: immediate IDLE, sel=00 (register holds its contents), no done pulse.
//   - Job throughput: 3 + n_eff cycles plus stall cycles. Accept-to-accept minimum is 3 + n_eff.
// STRUCTURE
//   - Shared include shift_sel_defs.vh: SEL_HOLD=2'b00, SEL_SHR=2'b01, SEL_SHL=2'b10, SEL_LOAD=2'b11.
//     Also the state encodings IDLE/LOAD/SHIFT/DONE.
//   - Sub-module shift_dncnt (CNT_W loadable down-counter: ld, en, zero flag). FSM and output registers stay in top.
// TESTING (bench instantiates shift_seq_ctrl driving the shift register, 10-unit clock)
//   1. Reset: rst_n=0 at t=0, then release -> sel=00, I=0000, ready=1, done=0; register A unchanged.
//   2. Right shift, data=1010, dir=0, n=2:
//      - sel sequence 11,01,01,00; A: 1010 -> x101 -> xx10 (serial-in bits per register);
//      - done pulses once, then ready=1.
//   3. Left shift, data=0011, dir=1, n=7 (saturates to 4):
//      - exactly 4 cycles of sel=10, then done; A's original bits fully shifted out.
//   4. Load-only: data=1111, n=0 -> sel 11 then 00; done 2 cycles after accept; A=1111.
//   5. Stall: data=1100, dir=0, n=3, stall high for 2 cycles mid-SHIFT:
//      - sel=00 for 2 cycles, total SHIFT cycles = 3, done delayed by 2.
//   6. Abort and ignore:
//      - rst_n pulsed low during SHIFT -> sel=00 immediately, no done, ready=1 after release;
//      - valid while busy -> ignored, no second load.

Source files
------------

// File: rtl/shift_seq_ctrl_pkg.sv
// Shared definitions for the shift-register sequencer: sel pin encodings,
// FSM states and default widths.
package shift_seq_ctrl_pkg;

    localparam int DATA_W    = 4;
    localparam int CNT_WIDTH = 3;

    typedef enum logic [1:0] {
        SEL_HOLD = 2'b00,
        SEL_SHR  = 2'b01,
        SEL_SHL  = 2'b10,
        SEL_LOAD = 2'b11
    } sel_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_LOAD  = 2'b01,
        ST_SHIFT = 2'b10,
        ST_DONE  = 2'b11
    } state_e;

endpackage

// File: rtl/shift_seq_ctrl_if.sv
// Job request channel: one word, direction and shift count per valid/ready handshake.
interface shift_seq_ctrl_if #(
    parameter int W     = 4,
    parameter int CNT_W = 3
);
    logic             valid;
    logic [W-1:0]     data;
    logic             dir;
    logic [CNT_W-1:0] n;
    logic             ready;

    modport master (output valid, data, dir, n, input ready);
    modport slave  (input valid, data, dir, n, output ready);
endinterface

// File: rtl/shift_dncnt.sv
// Loadable down-counter tracking remaining shifts; stops at zero.
module shift_dncnt #(
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ld_i,
    input  logic             en_i,
    input  logic [CNT_W-1:0] val_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             zero_o
);
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                cnt_q <= '0;
        else if (ld_i)             cnt_q <= val_i;
        else if (en_i && !zero_o)  cnt_q <= cnt_q - CNT_W'(1);
    end

    assign cnt_o  = cnt_q;
    assign zero_o = (cnt_q == '0);
endmodule

// File: rtl/shift_seq_ctrl.sv
// Sequencer for a universal shift register: one load cycle, n_eff shift cycles,
// one done cycle. All outputs are registered from the next-state decode.
module shift_seq_ctrl
    import shift_seq_ctrl_pkg::*;
#(
    parameter int W     = DATA_W,
    parameter int CNT_W = CNT_WIDTH
) (
    input  logic            clk,
    input  logic            rst_n,
    shift_seq_ctrl_if.slave job,
    input  logic            stall_i,
    output logic [1:0]      sel_o,
    output logic [W-1:0]    I_o,
    output logic            busy_o,
    output logic            done_o
);
    state_e           state_q, state_d;
    sel_e             sel_q, sel_d;
    logic [W-1:0]     data_q, data_d;
    logic             dir_q, dir_d;
    logic [CNT_W-1:0] neff_q, neff_d;
    logic             ready_q, ready_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             cnt_ld, cnt_en, cnt_zero, shifting;
    logic [CNT_W-1:0] cnt;

    shift_dncnt #(.CNT_W(CNT_W)) u_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .ld_i   (cnt_ld),
        .en_i   (cnt_en),
        .val_i  (neff_q),
        .cnt_o  (cnt),
        .zero_o (cnt_zero)
    );

    // The register shifts on an edge only when it currently sees a shift sel.
    assign shifting = (state_q == ST_SHIFT) && (sel_q != SEL_HOLD);

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        dir_d   = dir_q;
        neff_d  = neff_q;
        cnt_ld  = 1'b0;
        cnt_en  = 1'b0;
        sel_d   = SEL_HOLD;
        ready_d = 1'b0;
        busy_d  = 1'b1;
        done_d  = 1'b0;

        case (state_q)
            ST_IDLE: if (job.valid) begin
                data_d  = job.data;
                dir_d   = job.dir;
                neff_d  = (int'(job.n) > W) ? CNT_W'(W) : job.n;
                state_d = ST_LOAD;
            end
            ST_LOAD: begin
                if (neff_q != '0) begin
                    cnt_ld  = 1'b1;
                    state_d = ST_SHIFT;
                end else begin
                    state_d = ST_DONE;
                end
            end
            ST_SHIFT: begin
                cnt_en = shifting;
                if (cnt_zero || (shifting && cnt == CNT_W'(1))) state_d = ST_DONE;
            end
            default: state_d = ST_IDLE;
        endcase

        case (state_d)
            ST_IDLE:  begin ready_d = 1'b1; busy_d = 1'b0; end
            ST_LOAD:  sel_d = SEL_LOAD;
            // First shift cycle after LOAD always shifts; stall only acts inside SHIFT.
            ST_SHIFT: sel_d = (state_q == ST_SHIFT && stall_i) ? SEL_HOLD
                                                                 : (dir_d ? SEL_SHL : SEL_SHR);
            default:  done_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            sel_q   <= SEL_HOLD;
            data_q  <= '0;
            dir_q   <= 1'b0;
            neff_q  <= '0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            data_q  <= data_d;
            dir_q   <= dir_d;
            neff_q  <= neff_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign job.ready = ready_q;
    assign sel_o     = sel_q;
    assign I_o       = data_q;
    assign busy_o    = busy_q;
    assign done_o    = done_q;
endmodule
